bitcnt_iter_unit: RTL and testbench

Multi-cycle, parametrised bit-count unit for the Zbb-style count instructions: clz, ctz and cpop.
- Processes CHUNK bits per cycle over an XLEN-wide operand, trading latency for area and timing versus a single-cycle flat count.
- Sits in the execute stage as a variable-latency functional unit behind valid/ready handshakes, with a flush input for pipeline kills.

---
 rtl/bitcnt_pkg.sv | 31 +++
 rtl/bitcnt_chunk_count.sv | 31 +++
 rtl/bitcnt_iter_unit.sv | 140 ++++++++++++++
 tb/tb_bitcnt_iter_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitcnt_pkg.sv
// Shared types and helpers for the iterative bit-count unit (clz / ctz / cpop).
// The unit's optional early-exit path is selected by BITCNT_EARLY_EXIT_EN.
package bitcnt_pkg;

   localparam int unsigned MAX_XLEN = 64;

   typedef enum logic [1:0] {
      OP_CLZ  = 2'b00,
      OP_CTZ  = 2'b01,
      OP_CPOP = 2'b10,
      OP_RSVD = 2'b11
   } bitcnt_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } bitcnt_state_e;

   // Reverses the low 'width' bits of v; bits at and above 'width' come back zero.
   function automatic logic [MAX_XLEN-1:0] bit_reverse(input logic [MAX_XLEN-1:0] v,
                                                       input int unsigned       width);
      logic [MAX_XLEN-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_XLEN; i++) begin
         if (i < width) r[i] = v[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/bitcnt_chunk_count.sv
// Combinational per-chunk counter: leading zeros, population count and nonzero flag.
module chunk_count #(
   parameter int CHUNK = 8,
   localparam int CW   = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] chunk,
   output logic [CW-1:0]    lz,
   output logic [CW-1:0]    popcount,
   output logic             nonzero
);

   logic seen;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      lz       = '0;
      popcount = '0;
      seen     = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (chunk[i]) begin
            seen     = 1'b1;
            popcount = popcount + CW'(1);
         end else if (!seen) begin
            lz = lz + CW'(1);
         end
      end
   end

   assign nonzero = |chunk;

endmodule

// File: rtl/bitcnt_iter_unit.sv
// Multi-cycle clz/ctz/cpop unit, CHUNK bits per cycle, valid/ready on both sides with flush.
// Define BITCNT_EARLY_EXIT_EN to let clz/ctz finish on the first nonzero chunk.
module bitcnt_iter_unit
   import bitcnt_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result
);

   localparam int N_ITER = XLEN / CHUNK;
   localparam int AW     = $clog2(XLEN + 1);
   localparam int CW     = $clog2(CHUNK + 1);
   localparam int IW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   if ((XLEN % CHUNK) != 0 || CHUNK < 1 || CHUNK > XLEN || (CHUNK & (CHUNK - 1)) != 0
       || XLEN > MAX_XLEN) begin : g_bad_params
      $error("bitcnt_iter_unit: XLEN must be a multiple of a power-of-two CHUNK, XLEN <= MAX_XLEN");
   end

   bitcnt_state_e   state, state_n;
   bitcnt_op_e      op, op_n;
   logic [XLEN-1:0] sreg, sreg_n;
   logic [AW-1:0]   acc, acc_n;
   logic [IW-1:0]   iter, iter_n;
   logic            found, found_n;
   logic            out_valid_n;
   logic [XLEN-1:0] out_result_n;

   logic [CW-1:0]   lz, pop;
   logic            nz;
   logic            accept;
   logic            finish;
   logic            early;

   chunk_count #(.CHUNK(CHUNK)) u_chunk (
      .chunk    (sreg[XLEN-1 -: CHUNK]),
      .lz       (lz),
      .popcount (pop),
      .nonzero  (nz)
   );

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      state_n      = state;
      op_n         = op;
      sreg_n       = sreg;
      acc_n        = acc;
      iter_n       = iter;
      found_n      = found;
      out_valid_n  = out_valid;
      out_result_n = out_result;
      finish       = 1'b0;
      early        = 1'b0;

      case (state)
         BUSY: begin
            unique case (op)
               OP_CLZ, OP_CTZ: begin
                  // An all-zero chunk reports lz == CHUNK, so one add covers both cases.
                  if (!found) acc_n = acc + AW'(lz);
                  found_n = found | nz;
`ifdef BITCNT_EARLY_EXIT_EN
                  early = !found && nz;
`endif
               end
               OP_CPOP: acc_n = acc + AW'(pop);
               OP_RSVD: acc_n = '0;
            endcase
            sreg_n = sreg << CHUNK;
            iter_n = iter + IW'(1);
            finish = (iter == IW'(N_ITER - 1)) || (op == OP_RSVD) || early;
            if (finish) begin
               state_n      = DONE;
               out_valid_n  = 1'b1;
               out_result_n = XLEN'(acc_n);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n     = IDLE;
               out_valid_n = 1'b0;
            end
         end
         default: ;
      endcase

      // ctz is a clz of the bit-reversed operand.
      if (accept) begin
         state_n = BUSY;
         op_n    = bitcnt_op_e'(in_op);
         sreg_n  = (bitcnt_op_e'(in_op) == OP_CTZ)
                   ? XLEN'(bit_reverse(MAX_XLEN'(in_a), XLEN)) : in_a;
         acc_n   = '0;
         iter_n  = '0;
         found_n = 1'b0;
      end

      if (flush) begin
         state_n     = IDLE;
         out_valid_n = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op         <= OP_CLZ;
         sreg       <= '0;
         acc        <= '0;
         iter       <= '0;
         found      <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         state      <= state_n;
         op         <= op_n;
         sreg       <= sreg_n;
         acc        <= acc_n;
         iter       <= iter_n;
         found      <= found_n;
         out_valid  <= out_valid_n;
         out_result <= out_result_n;
      end
   end

endmodule

// File: tb/tb_bitcnt_iter_unit.sv
// Self-checking bench for bitcnt_iter_unit: directed cases plus randomized ops vs an arithmetic model.
module tb_bitcnt_iter_unit;
   import bitcnt_pkg::*;

   localparam int XLEN   = 32;
   localparam int CHUNK  = 8;
   localparam int N_ITER = XLEN / CHUNK;
   localparam int LIMIT  = 4 * N_ITER + 8;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_op;
   logic [XLEN-1:0] in_a;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;

   int checks   = 0;
   int failures = 0;

   bitcnt_iter_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model straight from the instruction definitions.
   function automatic int model_clz(input logic [XLEN-1:0] a);
      for (int i = XLEN - 1; i >= 0; i--) if (a[i]) return XLEN - 1 - i;
      return XLEN;
   endfunction

   function automatic int model_ctz(input logic [XLEN-1:0] a);
      for (int i = 0; i < XLEN; i++) if (a[i]) return i;
      return XLEN;
   endfunction

   function automatic int model_result(input logic [1:0] op, input logic [XLEN-1:0] a);
      case (op)
         2'b00:   return model_clz(a);
         2'b01:   return model_ctz(a);
         2'b10:   return $countones(a);
         default: return 0;
      endcase
   endfunction

   function automatic int model_latency(input logic [1:0] op, input logic [XLEN-1:0] a);
      int cnt;
      if (op == 2'b11) return 1;
`ifdef BITCNT_EARLY_EXIT_EN
      if (op == 2'b00 || op == 2'b01) begin
         cnt = (op == 2'b00) ? model_clz(a) : model_ctz(a);
         return (cnt / CHUNK + 1 < N_ITER) ? cnt / CHUNK + 1 : N_ITER;
      end
`endif
      cnt = N_ITER;
      return cnt;
   endfunction

   // Called just after a negedge; returns just after the negedge following the accept edge.
   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts clock edges after the accept edge until out_valid, bounded.
   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a);
      int lat;
      out_ready = 1'b1;
      check({tag, " in_ready"}, 64'(in_ready), 64'(1));
      issue(op, a);
      wait_result(lat);
      check({tag, " latency"}, 64'(lat), 64'(model_latency(op, a)));
      check({tag, " result"}, 64'(out_result), 64'(model_result(op, a)));
      @(negedge clk);
   endtask

   initial begin
      int            lat;
      logic          saw_valid;
      logic [1:0]    r_op;
      logic [XLEN-1:0] r_a;

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_a      = '0;
      out_ready = 1'b1;
      #12;
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset in_ready", 64'(in_ready), 64'(1));
      check("reset out_result", 64'(out_result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("clz 0x00010000", 2'b00, 32'h0001_0000);
      run_op("ctz 0x00000100", 2'b01, 32'h0000_0100);
      run_op("ctz zero", 2'b01, 32'h0);
      run_op("clz zero", 2'b00, 32'h0);
      run_op("clz 0x80000000", 2'b00, 32'h8000_0000);
      run_op("cpop 0xF0F00001", 2'b10, 32'hF0F0_0001);
      run_op("cpop ones", 2'b10, 32'hFFFF_FFFF);
      run_op("rsvd 0x12345678", 2'b11, 32'h1234_5678);

      // Back-pressure, then retire and accept on the same edge.
      out_ready = 1'b0;
      issue(2'b00, 32'h0001_0000);
      wait_result(lat);
      check("bp first result", 64'(out_result), 64'(15));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp hold valid", 64'(out_valid), 64'(1));
         check("bp hold result", 64'(out_result), 64'(15));
         check("bp in_ready low", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      #1;
      check("b2b in_ready", 64'(in_ready), 64'(1));
      issue(2'b00, 32'hFFFF_FFFF);
      check("b2b valid dropped", 64'(out_valid), 64'(0));
      wait_result(lat);
      check("b2b latency", 64'(lat), 64'(model_latency(2'b00, 32'hFFFF_FFFF)));
      check("b2b result", 64'(out_result), 64'(0));
      @(negedge clk);

      // Flush two cycles into a cpop, with a competing request in the flush cycle.
      issue(2'b10, 32'hF0F0_0001);
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_a     = 32'h0000_0001;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush out_valid", 64'(out_valid), 64'(0));
      check("flush in_ready", 64'(in_ready), 64'(1));
      saw_valid = 1'b0;
      for (int i = 0; i < N_ITER + 2; i++) begin
         @(negedge clk);
         saw_valid |= out_valid;
      end
      check("flush no result", 64'(saw_valid), 64'(0));

      // Flush while idle must also block a request.
      flush    = 1'b1;
      in_valid = 1'b1;
      in_op    = 2'b10;
      in_a     = 32'hFFFF_FFFF;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < N_ITER + 2; i++) begin
         @(negedge clk);
         saw_valid |= out_valid;
      end
      check("idle flush no accept", 64'(saw_valid), 64'(0));

      // Async reset mid-BUSY, with a stale nonzero result on out_result.
      run_op("cpop 0xFF", 2'b10, 32'h0000_00FF);
      issue(2'b10, 32'hFFFF_FFFF);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", 64'(out_valid), 64'(0));
      check("async rst in_ready", 64'(in_ready), 64'(1));
      check("async rst out_result", 64'(out_result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("post-reset clz", 2'b00, 32'h0001_0000);

      // Randomized ops against the model.
      for (int n = 0; n < 60; n++) begin
         r_op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       r_a = $urandom;
            1:       r_a = XLEN'(1) << $urandom_range(0, XLEN - 1);
            2:       r_a = '0;
            default: r_a = $urandom & (XLEN'(32'hFF) << (CHUNK * $urandom_range(0, N_ITER - 1)));
         endcase
         run_op($sformatf("rand%0d op%0d a=%08h", n, r_op, r_a), r_op, r_a);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
